// File: rtl/ex_div_ctrl_pkg.sv
// Shared encodings for the EX-stage divider initiator.
// Widths and handshake levels match the divider it drives.
package ex_div_ctrl_pkg;

  localparam int unsigned RegBus       = 32;
  localparam int unsigned DoubleRegBus = 64;

  localparam logic DivStart       = 1'b1;
  localparam logic DivStop        = 1'b0;
  localparam logic DivResultReady = 1'b1;
  localparam logic FlushDisable   = 1'b0;

  // Two start-low cycles let a divider stuck in its end path return to free.
  localparam logic [1:0] AbortCycles = 2'd2;

  typedef enum logic [1:0] {
    ExDivIdle  = 2'b00,
    ExDivBusy  = 2'b01,
    ExDivDone  = 2'b10,
    ExDivAbort = 2'b11
  } ex_div_state_e;

endpackage

// File: rtl/ex_div_ctrl.sv
// EX-stage initiator for the iterative divider: issues start/annul, stalls EX
// until the {rem, quo} pair returns, and presents it for HI/LO writeback.
module ex_div_ctrl
  import ex_div_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    ex_div_valid_i,
  input  logic                    ex_div_signed_i,
  input  logic [RegBus-1:0]       ex_rs_i,
  input  logic [RegBus-1:0]       ex_rt_i,
  input  logic                    flush_i,
  input  logic                    stall_i,
  output logic                    stall_req_o,
  output logic                    result_valid_o,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    div_start_o,
  output logic                    div_annul_o,
  output logic                    div_signed_o,
  output logic [RegBus-1:0]       div_op1_o,
  output logic [RegBus-1:0]       div_op2_o,
  input  logic [DoubleRegBus-1:0] div_result_i,
  input  logic                    div_ready_i
);

  ex_div_state_e           r_state, w_state_nxt;
  logic [1:0]              r_abort_cnt, w_abort_cnt_nxt;
  logic [RegBus-1:0]       r_op1, r_op2;
  logic                    r_sgn;
  logic [DoubleRegBus-1:0] r_result;
  logic                    w_accept;
  logic                    w_latch_result;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= ExDivIdle;
      r_abort_cnt <= 2'd0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_sgn       <= 1'b0;
      r_result    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_abort_cnt <= w_abort_cnt_nxt;
      if (w_accept) begin
        r_op1 <= ex_rs_i;
        r_op2 <= ex_rt_i;
        r_sgn <= ex_div_signed_i;
      end
      if (w_latch_result) begin
        r_result <= div_result_i;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_abort_cnt_nxt = r_abort_cnt;
    w_accept        = 1'b0;
    w_latch_result  = 1'b0;
    stall_req_o     = 1'b0;
    result_valid_o  = 1'b0;
    div_start_o     = DivStop;
    div_annul_o     = 1'b0;

    unique case (r_state)
      ExDivIdle: begin
        if (ex_div_valid_i && (flush_i == FlushDisable)) begin
          w_accept    = 1'b1;
          stall_req_o = 1'b1;
          w_state_nxt = ExDivBusy;
        end
      end
      ExDivBusy: begin
        stall_req_o = 1'b1;
        // A flush outranks a same-cycle ready: the result is dropped.
        if (flush_i != FlushDisable) begin
          div_annul_o     = 1'b1;
          w_abort_cnt_nxt = AbortCycles;
          w_state_nxt     = ExDivAbort;
        end else begin
          div_start_o = DivStart;
          if (div_ready_i == DivResultReady) begin
            w_latch_result = 1'b1;
            w_state_nxt    = ExDivDone;
          end
        end
      end
      ExDivDone: begin
        result_valid_o = !flush_i;
        if (flush_i || !stall_i) begin
          w_state_nxt = ExDivIdle;
        end
      end
      ExDivAbort: begin
        div_annul_o     = 1'b1;
        stall_req_o     = ex_div_valid_i;
        w_abort_cnt_nxt = r_abort_cnt - 2'd1;
        if (r_abort_cnt <= 2'd1) begin
          w_state_nxt = ExDivIdle;
        end
      end
      default: begin
        w_state_nxt = ExDivIdle;
      end
    endcase
  end

  // Operands come from registers so they stay fixed for the divider's sign fixup.
  assign div_op1_o    = r_op1;
  assign div_op2_o    = r_op2;
  assign div_signed_o = r_sgn;
  assign result_o     = r_result;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Bench for ex_div_ctrl: behavioural divider beside the DUT, directed
// scenarios with exact timing, then randomized traffic against a scoreboard.
module tb_ex_div_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_div_valid, ex_div_signed, flush, stall;
  logic [31:0] ex_rs, ex_rt;
  logic        stall_req, result_valid;
  logic [63:0] result;
  logic        div_start, div_annul, div_signed;
  logic [31:0] div_op1, div_op2;
  logic [63:0] div_result;
  logic        div_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int div_lat  = 34;

  always #5 clk = ~clk;

  ex_div_ctrl u_dut (
    .clk            (clk),
    .resetn         (resetn),
    .ex_div_valid_i (ex_div_valid),
    .ex_div_signed_i(ex_div_signed),
    .ex_rs_i        (ex_rs),
    .ex_rt_i        (ex_rt),
    .flush_i        (flush),
    .stall_i        (stall),
    .stall_req_o    (stall_req),
    .result_valid_o (result_valid),
    .result_o       (result),
    .div_start_o    (div_start),
    .div_annul_o    (div_annul),
    .div_signed_o   (div_signed),
    .div_op1_o      (div_op1),
    .div_op2_o      (div_op2),
    .div_result_i   (div_result),
    .div_ready_i    (div_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // MIPS DIV/DIVU semantics: truncating quotient, remainder takes dividend sign.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    int signed qs, rs;
    if (b == 32'd0) return 64'd0;
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    qs = $signed(a) / $signed(b);
    rs = $signed(a) % $signed(b);
    return {rs, qs};
  endfunction

  // Divider model: ready div_lat cycles after start is first seen, holds
  // ready until start drops, aborts on annul while counting.
  logic        dv_busy;
  int          dv_cnt;
  logic [31:0] dv_a, dv_b;
  logic        dv_s;

  always @(posedge clk) begin
    if (!resetn) begin
      dv_busy    <= 1'b0;
      dv_cnt     <= 0;
      div_ready  <= 1'b0;
      div_result <= 64'd0;
      dv_a       <= 32'd0;
      dv_b       <= 32'd0;
      dv_s       <= 1'b0;
    end else if (dv_busy) begin
      if (div_annul || !div_start) begin
        dv_busy <= 1'b0;
      end else if (dv_cnt <= 1) begin
        dv_busy    <= 1'b0;
        div_ready  <= 1'b1;
        div_result <= ref_div(dv_a, dv_b, dv_s);
      end else begin
        dv_cnt <= dv_cnt - 1;
      end
    end else if (div_ready) begin
      if (!div_start) begin
        div_ready  <= 1'b0;
        div_result <= 64'd0;
      end
    end else if (div_start && !div_annul) begin
      dv_busy <= 1'b1;
      dv_cnt  <= div_lat - 1;
      dv_a    <= div_op1;
      dv_b    <= div_op2;
      dv_s    <= div_signed;
    end
  end

  always @(negedge clk) begin
    if (resetn && dv_busy) begin
      check("busy_start_or_annul", {63'd0, div_start | div_annul}, 64'd1);
      check("busy_stall_req", {63'd0, stall_req}, 64'd1);
      check("busy_op1_stable", {32'd0, div_op1}, {32'd0, dv_a});
      check("busy_op2_stable", {32'd0, div_op2}, {32'd0, dv_b});
      check("busy_sgn_stable", {63'd0, div_signed}, {63'd0, dv_s});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stall_req"}, {63'd0, stall_req}, 64'd0);
    check({tag, "_rv"}, {63'd0, result_valid}, 64'd0);
    check({tag, "_result"}, result, 64'd0);
    check({tag, "_start"}, {63'd0, div_start}, 64'd0);
    check({tag, "_annul"}, {63'd0, div_annul}, 64'd0);
    check({tag, "_signed"}, {63'd0, div_signed}, 64'd0);
    check({tag, "_op1"}, {32'd0, div_op1}, 64'd0);
    check({tag, "_op2"}, {32'd0, div_op2}, 64'd0);
  endtask

  // Issue one op at the current cycle (T0); the result must appear at T(lat+2)
  // and be held for `hold` stalled cycles before committing once.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int lat, input int hold,
                        input logic [63:0] exp);
    int done_t;
    int commits;
    done_t  = lat + 2;
    commits = 0;
    div_lat = lat;
    ex_div_valid = 1'b1; ex_rs = a; ex_rt = b; ex_div_signed = s; flush = 1'b0;
    for (int t = 0; t <= done_t + hold; t++) begin
      stall = (t >= done_t) && (t < done_t + hold);
      @(negedge clk);
      if (t < done_t) begin
        check({tag, "_stall_req"}, {63'd0, stall_req}, 64'd1);
        check({tag, "_rv_early"}, {63'd0, result_valid}, 64'd0);
        check({tag, "_start"}, {63'd0, div_start}, {63'd0, t >= 1});
        check({tag, "_annul"}, {63'd0, div_annul}, 64'd0);
        if (t >= 1) begin
          check({tag, "_op1"}, {32'd0, div_op1}, {32'd0, a});
          check({tag, "_op2"}, {32'd0, div_op2}, {32'd0, b});
          check({tag, "_sgn"}, {63'd0, div_signed}, {63'd0, s});
        end
      end else begin
        check({tag, "_rv"}, {63'd0, result_valid}, 64'd1);
        check({tag, "_stall_req_done"}, {63'd0, stall_req}, 64'd0);
        check({tag, "_start_done"}, {63'd0, div_start}, 64'd0);
        check({tag, "_result"}, result, exp);
        if (result_valid && !stall) commits++;
      end
      step();
    end
    ex_div_valid = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    check({tag, "_start_after"}, {63'd0, div_start}, 64'd0);
    check({tag, "_rv_after"}, {63'd0, result_valid}, 64'd0);
    check({tag, "_commits"}, 64'(commits), 64'd1);
    step();
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s, done;
    int          kill_at, t, n_commit, n_kill;
    logic [63:0] exp_q;

    resetn = 1'b0;
    ex_div_valid = 1'b0; ex_div_signed = 1'b0; ex_rs = 32'd0; ex_rt = 32'd0;
    flush = 1'b0; stall = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check_reset_outputs("reset");
    step();
    resetn = 1'b1;
    step();

    run_op("divu_100_7", 32'd100, 32'd7, 1'b0, 34, 0, {32'd2, 32'd14});
    run_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 10, 0, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div_by_zero", 32'd1234, 32'd0, 1'b1, 3, 0, 64'd0);
    run_op("done_stall", 32'd1000, 32'd33, 1'b0, 8, 5, {32'd10, 32'd30});

    // Flush at T10 of a busy op; next DIVU 9/3 waits in EX from T11.
    div_lat = 34;
    ex_div_valid = 1'b1; ex_rs = 32'd100; ex_rt = 32'd7; ex_div_signed = 1'b0;
    for (int i = 0; i <= 12; i++) begin
      flush = (i == 10);
      if (i == 11) begin
        ex_rs = 32'd9; ex_rt = 32'd3; ex_div_signed = 1'b0;
      end
      @(negedge clk);
      if (i >= 10) begin
        check("flush_annul", {63'd0, div_annul}, 64'd1);
        check("flush_start", {63'd0, div_start}, 64'd0);
        check("flush_rv", {63'd0, result_valid}, 64'd0);
      end
      if (i >= 11) check("abort_stall_req", {63'd0, stall_req}, 64'd1);
      step();
    end
    flush = 1'b0;
    run_op("abort_next", 32'd9, 32'd3, 1'b0, 5, 0, {32'd0, 32'd3});

    // Flush in the same cycle as div_ready: result dropped, ABORT entered.
    div_lat = 6;
    ex_div_valid = 1'b1; ex_rs = 32'd100; ex_rt = 32'd7; ex_div_signed = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      flush = (i == 7);
      if (i == 8) ex_div_valid = 1'b0;
      @(negedge clk);
      if (i == 7) check("fr_ready_seen", {63'd0, div_ready}, 64'd1);
      if (i >= 7) begin
        check("fr_rv", {63'd0, result_valid}, 64'd0);
        check("fr_start", {63'd0, div_start}, 64'd0);
        check("fr_result_kept", result, {32'd0, 32'd3});
        check("fr_annul", {63'd0, div_annul}, {63'd0, i <= 9});
      end
      if (i >= 8) check("fr_stall_req", {63'd0, stall_req}, 64'd0);
      step();
    end
    flush = 1'b0;

    // Reset in the middle of a signed op.
    div_lat = 34;
    ex_div_valid = 1'b1; ex_rs = 32'hFFFF_FFF9; ex_rt = 32'd2; ex_div_signed = 1'b1;
    repeat (5) step();
    ex_div_valid = 1'b0;
    resetn = 1'b0;
    step();
    @(negedge clk);
    check_reset_outputs("mid_reset");
    resetn = 1'b1;
    step();

    // Randomized traffic: random operands, latency, flushes and DONE stalls.
    n_commit = 0;
    n_kill   = 0;
    for (int n = 0; n < 60; n++) begin
      ex_div_valid = 1'b0;
      repeat ($urandom_range(0, 2)) step();
      case ($urandom_range(0, 3))
        0:       a = $urandom_range(0, 200);
        1:       a = 32'hFFFF_FF00 | $urandom_range(0, 255);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 20);
        3:       b = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        default: b = $urandom;
      endcase
      s       = 1'($urandom_range(0, 1));
      div_lat = $urandom_range(2, 40);
      kill_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 45) : -1;
      exp_q   = ref_div(a, b, s);
      ex_div_valid = 1'b1; ex_rs = a; ex_rt = b; ex_div_signed = s;
      done = 1'b0;
      t    = 0;
      while (!done && t < 300) begin
        stall = ($urandom_range(0, 3) == 0);
        flush = (t == kill_at);
        @(negedge clk);
        if (flush) begin
          check("rand_rv_under_flush", {63'd0, result_valid}, 64'd0);
          done = 1'b1;
          n_kill++;
        end else if (result_valid && !stall) begin
          check("rand_result", result, exp_q);
          done = 1'b1;
          n_commit++;
        end
        step();
        t++;
      end
      check("rand_complete", {63'd0, done}, 64'd1);
      ex_div_valid = 1'b0;
      flush = 1'b0;
      stall = 1'b0;
    end
    check("rand_all_retired", 64'(n_commit + n_kill), 64'd60);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
